// File: rtl/cpu_pkg.sv
// Shared 2A03 core definitions: addressing modes, ALU opcodes, EA sequencer states.
package cpu_pkg;

    typedef enum logic [2:0] {
        MODE_ZP   = 3'd0,
        MODE_ZPX  = 3'd1,
        MODE_ZPY  = 3'd2,
        MODE_ABS  = 3'd3,
        MODE_ABSX = 3'd4,
        MODE_ABSY = 3'd5,
        MODE_INDX = 3'd6,
        MODE_INDY = 3'd7
    } mode_t;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_INC = 4'h5;
    localparam logic [3:0] ALU_NOP = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_IDX_ADD  = 3'd1,
        ST_PTR_LO   = 3'd2,
        ST_PTR_HI   = 3'd3,
        ST_PTR_WAIT = 3'd4,
        ST_FIXUP    = 3'd5,
        ST_DONE     = 3'd6
    } ea_state_t;

    // Modes indexed by X; everything else indexed uses Y.
    function automatic logic uses_x(input mode_t m);
        return (m == MODE_ZPX) || (m == MODE_ABSX) || (m == MODE_INDX);
    endfunction

    // Modes whose operand supplies a high byte.
    function automatic logic is_abs(input mode_t m);
        return (m == MODE_ABS) || (m == MODE_ABSX) || (m == MODE_ABSY);
    endfunction

endpackage

// File: rtl/ea_sequencer.sv
// Effective-address sequencer: walks each 6502 addressing mode through the
// shared external ALU and the zero-page read port, producing a 16-bit EA.
module ea_sequencer
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mode,
    input  logic        force_fixup,
    input  logic [7:0]  op_lo,
    input  logic [7:0]  op_hi,
    input  logic [7:0]  idx_x,
    input  logic [7:0]  idx_y,
    output logic        rd_req,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic [3:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_cin,
    input  logic [8:0]  alu_f,
    output logic        busy,
    output logic        done,
    output logic [15:0] ea,
    output logic        page_cross
);

    ea_state_t state_q, state_d;
    mode_t     mode_q, mode_d;
    logic      ff_q, ff_d;
    logic      cy_q, cy_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] lo_q, lo_d;
    logic [7:0] hi_q, hi_d;
    logic [7:0] ptr_q, ptr_d;
    logic [7:0] ptr1_q, ptr1_d;
    mode_t     mode_in;

    assign mode_in = mode_t'(mode);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_ZP;
            ff_q    <= 1'b0;
            cy_q    <= 1'b0;
            idx_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            ptr_q   <= '0;
            ptr1_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            ff_q    <= ff_d;
            cy_q    <= cy_d;
            idx_q   <= idx_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            ptr_q   <= ptr_d;
            ptr1_q  <= ptr1_d;
        end
    end

    // Next-state selection per addressing mode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (mode_in == MODE_ZP || mode_in == MODE_ABS) state_d = ST_DONE;
                    else if (mode_in == MODE_INDY)                 state_d = ST_PTR_LO;
                    else                                           state_d = ST_IDX_ADD;
                end
            end
            ST_IDX_ADD: begin
                if (mode_q == MODE_INDX)
                    state_d = ST_PTR_LO;
                else if ((mode_q == MODE_ABSX || mode_q == MODE_ABSY) && (alu_f[8] || ff_q))
                    state_d = ST_FIXUP;
                else
                    state_d = ST_DONE;
            end
            ST_PTR_LO:   state_d = ST_PTR_HI;
            ST_PTR_HI:   state_d = ST_PTR_WAIT;
            ST_PTR_WAIT: begin
                if (mode_q == MODE_INDY && (alu_f[8] || ff_q)) state_d = ST_FIXUP;
                else                                           state_d = ST_DONE;
            end
            ST_FIXUP:    state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // ALU request, read port and status outputs decoded from the current state.
    always_comb begin
        alu_op  = ALU_NOP;
        alu_a   = '0;
        alu_b   = '0;
        rd_req  = 1'b0;
        rd_addr = '0;
        busy    = (state_q != ST_IDLE);
        done    = (state_q == ST_DONE);
        unique case (state_q)
            ST_IDX_ADD: begin
                alu_op = ALU_ADD;
                alu_a  = lo_q;
                alu_b  = idx_q;
            end
            ST_PTR_LO: begin
                rd_req  = 1'b1;
                rd_addr = {8'h00, ptr_q};
                alu_op  = ALU_INC;
                alu_a   = ptr_q;
            end
            ST_PTR_HI: begin
                rd_req  = 1'b1;
                rd_addr = {8'h00, ptr1_q};
            end
            ST_PTR_WAIT: begin
                // rd_data here is the pointer high byte; lo_q already holds the low byte.
                if (mode_q == MODE_INDY) begin
                    alu_op = ALU_ADD;
                    alu_a  = lo_q;
                    alu_b  = idx_q;
                end
            end
            ST_FIXUP: begin
                alu_op = cy_q ? ALU_INC : ALU_NOP;
                alu_a  = hi_q;
            end
            default: ;
        endcase
    end

    // Datapath next values: operand latch on start, then ALU and read results.
    always_comb begin
        mode_d = mode_q;
        ff_d   = ff_q;
        cy_d   = cy_q;
        idx_d  = idx_q;
        lo_d   = lo_q;
        hi_d   = hi_q;
        ptr_d  = ptr_q;
        ptr1_d = ptr1_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d = mode_in;
                    ff_d   = force_fixup;
                    cy_d   = 1'b0;
                    idx_d  = uses_x(mode_in) ? idx_x : idx_y;
                    lo_d   = op_lo;
                    hi_d   = is_abs(mode_in) ? op_hi : 8'h00;
                    ptr_d  = op_lo;
                end
            end
            ST_IDX_ADD: begin
                lo_d  = alu_f[7:0];
                cy_d  = alu_f[8];
                ptr_d = alu_f[7:0];
            end
            ST_PTR_LO:  ptr1_d = alu_f[7:0];
            ST_PTR_HI:  lo_d   = rd_data;
            ST_PTR_WAIT: begin
                hi_d = rd_data;
                if (mode_q == MODE_INDY) begin
                    lo_d = alu_f[7:0];
                    cy_d = alu_f[8];
                end
            end
            ST_FIXUP:   hi_d = alu_f[7:0];
            default: ;
        endcase
    end

    assign alu_cin    = 1'b0;
    assign ea         = {hi_q, lo_q};
    assign page_cross = cy_q &&
                        (mode_q == MODE_ABSX || mode_q == MODE_ABSY || mode_q == MODE_INDY);

endmodule

// File: tb/tb_ea_sequencer.sv
// Directed bench for ea_sequencer with a behavioural ALU and zero-page memory.
module tb_ea_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mode;
    logic        force_fixup;
    logic [7:0]  op_lo, op_hi, idx_x, idx_y;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a, alu_b;
    logic        alu_cin;
    logic [8:0]  alu_f;
    logic        busy, done, page_cross;
    logic [15:0] ea;

    logic [7:0]  mem [256];
    logic [15:0] rd_log [$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ea_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .force_fixup(force_fixup), .op_lo(op_lo), .op_hi(op_hi),
        .idx_x(idx_x), .idx_y(idx_y), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rd_data), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_cin(alu_cin), .alu_f(alu_f), .busy(busy), .done(done),
        .ea(ea), .page_cross(page_cross)
    );

    // Reference ALU: ADD, INC, anything else passes a.
    always_comb begin
        case (alu_op)
            4'h0:    alu_f = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
            4'h5:    alu_f = {1'b0, alu_a} + 9'd1;
            default: alu_f = {1'b0, alu_a};
        endcase
    end

    // Zero-page read port, data one cycle after the request.
    always @(posedge clk) begin
        if (rd_req) rd_data <= mem[rd_addr[7:0]];
    end

    // Launch one operation and count cycles to the first done (no checking here).
    task automatic run_op(input logic [2:0] m, input logic [7:0] lo, input logic [7:0] hi,
                          input logic [7:0] x, input logic [7:0] y, input logic ff,
                          input logic hammer, output int cyc, output logic timeout);
        @(negedge clk);
        mode = m; op_lo = lo; op_hi = hi; idx_x = x; idx_y = y;
        force_fixup = ff; start = 1'b1;
        cyc = 0; timeout = 1'b1;
        rd_log.delete();
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (hammer) begin
                mode = 3'd0; op_lo = 8'h77; force_fixup = 1'b0;
            end else begin
                start = 1'b0;
            end
            if (rd_req) rd_log.push_back(rd_addr);
            if (done) begin
                cyc = i; timeout = 1'b0;
                start = 1'b0;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; mode = '0; force_fixup = 1'b0;
        op_lo = '0; op_hi = '0; idx_x = '0; idx_y = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy, done, page_cross, rd_req, alu_cin} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=00000", {busy, done, page_cross, rd_req, alu_cin});
        end
        total++;
        if (ea !== 16'h0000 || rd_addr !== 16'h0000) begin
            bad++; $display("FAIL reset_addr ea=%h rd_addr=%h want 0000/0000", ea, rd_addr);
        end
        total++;
        if (alu_op !== 4'hF || alu_a !== 8'h00 || alu_b !== 8'h00) begin
            bad++; $display("FAIL reset_alu op=%h a=%h b=%h want F/00/00", alu_op, alu_a, alu_b);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Generic directed case: mode, operands, expected cycle, EA and page cross.
    task automatic test_case(input string name, input logic [2:0] m, input logic [7:0] lo,
                             input logic [7:0] hi, input logic [7:0] x, input logic [7:0] y,
                             input logic ff, input int exp_cyc, input logic [15:0] exp_ea,
                             input logic exp_pc);
        int c; logic to;
        run_op(m, lo, hi, x, y, ff, 1'b0, c, to);
        total++;
        if (to || c != exp_cyc) begin
            bad++; $display("FAIL %s_cycle got=%0d timeout=%0b want=%0d", name, c, to, exp_cyc);
        end
        total++;
        if (ea !== exp_ea || page_cross !== exp_pc) begin
            bad++; $display("FAIL %s_ea got=%h pc=%b want=%h pc=%b", name, ea, page_cross, exp_ea, exp_pc);
        end
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || ea !== exp_ea || page_cross !== exp_pc) begin
            bad++; $display("FAIL %s_hold busy=%b done=%b ea=%h pc=%b want 0/0/%h/%b",
                            name, busy, done, ea, page_cross, exp_ea, exp_pc);
        end
    endtask

    task automatic test_modes;
        test_case("zp",        3'd0, 8'h42, 8'hAA, 8'h11, 8'h22, 1'b0, 1, 16'h0042, 1'b0);
        test_case("abs",       3'd3, 8'hCD, 8'hAB, 8'h11, 8'h22, 1'b0, 1, 16'hABCD, 1'b0);
        test_case("absx_cross",3'd4, 8'hF0, 8'h12, 8'h20, 8'h00, 1'b0, 3, 16'h1310, 1'b1);
        test_case("absx_nox",  3'd4, 8'hF0, 8'h12, 8'h05, 8'h00, 1'b0, 2, 16'h12F5, 1'b0);
        test_case("absy_force",3'd5, 8'h34, 8'h12, 8'hFF, 8'h01, 1'b1, 3, 16'h1235, 1'b0);
        test_case("zpx_wrap",  3'd1, 8'hF0, 8'h99, 8'h20, 8'h00, 1'b0, 2, 16'h0010, 1'b0);
        test_case("zpy",       3'd2, 8'h80, 8'hAA, 8'h40, 8'h05, 1'b0, 2, 16'h0085, 1'b0);
    endtask

    task automatic test_indirect;
        mem[8'hFF] = 8'h34; mem[8'h00] = 8'h12;
        mem[8'h40] = 8'hF8; mem[8'h41] = 8'h20;
        test_case("indx", 3'd6, 8'hFE, 8'h55, 8'h01, 8'h00, 1'b0, 5, 16'h1234, 1'b0);
        // rd_log was filled by the indx run just above
        total++;
        if (rd_log.size() != 2) begin
            bad++; $display("FAIL indx_rdcount got=%0d want=2", rd_log.size());
        end else if (rd_log[0] !== 16'h00FF || rd_log[1] !== 16'h0000) begin
            bad++; $display("FAIL indx_rdaddr got=%h,%h want=00FF,0000", rd_log[0], rd_log[1]);
        end
        test_case("indy_cross", 3'd7, 8'h40, 8'h55, 8'h00, 8'h10, 1'b0, 5, 16'h2108, 1'b1);
        test_case("indy_force", 3'd7, 8'h40, 8'h55, 8'h00, 8'h01, 1'b1, 5, 16'h20F9, 1'b0);
        test_case("indy_fast",  3'd7, 8'h40, 8'h55, 8'h00, 8'h02, 1'b0, 4, 16'h20FA, 1'b0);
    endtask

    task automatic test_back_to_back;
        int c; logic to; int extra;
        mem[8'hFF] = 8'h34; mem[8'h00] = 8'h12;
        run_op(3'd6, 8'hFE, 8'h00, 8'h01, 8'h00, 1'b0, 1'b1, c, to);
        total++;
        if (to || c != 5 || ea !== 16'h1234) begin
            bad++; $display("FAIL hammer_first cyc=%0d timeout=%0b ea=%h want 5/0/1234", c, to, ea);
        end
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        total++;
        if (extra != 0 || ea !== 16'h1234 || busy !== 1'b0) begin
            bad++; $display("FAIL hammer_after extra_done=%0d ea=%h busy=%b want 0/1234/0", extra, ea, busy);
        end
        test_case("zp_next", 3'd0, 8'h77, 8'h00, 8'h00, 8'h00, 1'b0, 1, 16'h0077, 1'b0);
    endtask

    task automatic test_reset_midop;
        int seen_done;
        mem[8'hFF] = 8'h34; mem[8'h00] = 8'h12;
        @(negedge clk);
        mode = 3'd6; op_lo = 8'hFE; idx_x = 8'h01; force_fixup = 1'b0; start = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) seen_done++;
        end
        total++;
        if (rd_req !== 1'b1 || rd_addr !== 16'h0000) begin
            bad++; $display("FAIL midop_ptrhi rd_req=%b rd_addr=%h want 1/0000", rd_req, rd_addr);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        if (done) seen_done++;
        reset = 1'b0;
        total++;
        if ({busy, done, page_cross, rd_req} !== 4'b0 || ea !== 16'h0000 || rd_addr !== 16'h0000 ||
            alu_op !== 4'hF || alu_a !== 8'h00 || alu_b !== 8'h00 || seen_done != 0) begin
            bad++; $display("FAIL midop_reset busy=%b done=%b pc=%b rd=%b ea=%h addr=%h op=%h seen=%0d want all reset",
                            busy, done, page_cross, rd_req, ea, rd_addr, alu_op, seen_done);
        end
        test_case("abs_after_reset", 3'd3, 8'h78, 8'h56, 8'h00, 8'h00, 1'b0, 1, 16'h5678, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rd_data = 8'h00;
        test_reset();
        test_modes();
        test_indirect();
        test_back_to_back();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
